mlp_weight_server: RTL and testbench

- Responder side of the MLP layer-weight interface: accepts a layer-number request from the MLP controller and reads that layer's weights from a single-port weight SRAM, one word per cycle.
- Assembles the words into one wide weight bus and signals data ready back to the controller.
- Sits between the MLP controller and the on-chip weight memory.
- Keeps a one-entry cache of the last layer served, so a repeat request skips the SRAM.

---
 rtl/mlp_weight_server.sv | 125 ++++++++++++
 tb/tb_mlp_weight_server.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mlp_weight_server.sv
// Layer-weight responder: fetches one layer's words from a single-port SRAM into a
// wide weight bus, with a one-entry cache of the last layer served.
module mlp_weight_server #(
    parameter int DATA_WIDTH      = 32,
    parameter int NUMLAYERBITS    = 4,
    parameter int NUM_LAYERS      = 4,
    parameter int WORDS_PER_LAYER = 8,
    parameter int ADDR_WIDTH      = 8,
    parameter int BASE_ADDR       = 0
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  req_valid,
    input  logic [NUMLAYERBITS-1:0]               req_layer,
    output logic                                  req_ready,
    output logic                                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0]                 mem_addr,
    input  logic [DATA_WIDTH-1:0]                 mem_rdata,
    output logic [DATA_WIDTH*WORDS_PER_LAYER-1:0] weights,
    output logic                                  data_ready,
    output logic                                  err,
    output logic                                  busy
);

    localparam int CNT_W = $clog2(WORDS_PER_LAYER + 1);
    localparam logic [CNT_W-1:0]      NUM_WORDS = CNT_W'(WORDS_PER_LAYER);
    localparam logic [CNT_W-1:0]      LAST_WORD = CNT_W'(WORDS_PER_LAYER - 1);
    localparam logic [ADDR_WIDTH-1:0] BASE_A    = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] WORDS_A   = ADDR_WIDTH'(WORDS_PER_LAYER);

    typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

    state_t                  state;
    logic [CNT_W-1:0]        issue_cnt;
    logic [CNT_W-1:0]        word_cnt;
    logic                    rd_pend;
    logic                    cache_valid;
    logic [NUMLAYERBITS-1:0] cached_layer;

    logic                  accept;
    logic                  layer_oob;
    logic                  cache_hit;
    logic [ADDR_WIDTH-1:0] fetch_base;

    assign accept     = req_valid && req_ready;
    assign layer_oob  = 32'(req_layer) >= NUM_LAYERS;
    assign cache_hit  = cache_valid && (req_layer == cached_layer);
    assign fetch_base = BASE_A + ADDR_WIDTH'(req_layer) * WORDS_A;

    // rd_pend marks a cycle whose mem_rdata answers the previous cycle's strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            req_ready    <= 1'b0;
            mem_rd_en    <= 1'b0;
            mem_addr     <= '0;
            // NOTE: weights is a flop bank driving a port, not a RAM, so it is cleared on reset.
            weights      <= '0;
            data_ready   <= 1'b0;
            err          <= 1'b0;
            busy         <= 1'b0;
            issue_cnt    <= '0;
            word_cnt     <= '0;
            rd_pend      <= 1'b0;
            cache_valid  <= 1'b0;
            cached_layer <= '0;
        end else begin
            // NOTE: every state register uses <= so all updates see pre-edge values.
            case (state)
                IDLE, DONE: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        if (layer_oob) begin
                            state      <= DONE;
                            err        <= 1'b1;
                            data_ready <= 1'b1;
                        end else if (cache_hit) begin
                            state      <= DONE;
                            err        <= 1'b0;
                            data_ready <= 1'b1;
                        end else begin
                            state        <= FETCH;
                            req_ready    <= 1'b0;
                            busy         <= 1'b1;
                            data_ready   <= 1'b0;
                            err          <= 1'b0;
                            cache_valid  <= 1'b0;
                            cached_layer <= req_layer;
                            mem_rd_en    <= 1'b1;
                            mem_addr     <= fetch_base;
                            issue_cnt    <= CNT_W'(1);
                            word_cnt     <= '0;
                            rd_pend      <= 1'b0;
                        end
                    end
                end
                FETCH: begin
                    rd_pend <= mem_rd_en;
                    if (issue_cnt < NUM_WORDS) begin
                        mem_addr  <= mem_addr + ADDR_WIDTH'(1);
                        issue_cnt <= issue_cnt + CNT_W'(1);
                    end else begin
                        mem_rd_en <= 1'b0;
                    end
                    if (rd_pend) begin
                        for (int k = 0; k < WORDS_PER_LAYER; k++) begin
                            if (word_cnt == CNT_W'(k))
                                weights[k*DATA_WIDTH +: DATA_WIDTH] <= mem_rdata;
                        end
                        word_cnt <= word_cnt + CNT_W'(1);
                        if (word_cnt == LAST_WORD) begin
                            state       <= DONE;
                            busy        <= 1'b0;
                            req_ready   <= 1'b1;
                            data_ready  <= 1'b1;
                            cache_valid <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mlp_weight_server.sv
// Directed bench for mlp_weight_server: default build plus a one-word-per-layer
// build at base address 4, each served by a synchronous-read SRAM model.
module tb_mlp_weight_server;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Default instance (8 words per layer, base 0)
    logic         req_valid, req_ready, mem_rd_en, data_ready, err, busy;
    logic [3:0]   req_layer;
    logic [7:0]   mem_addr;
    logic [31:0]  mem_rdata;
    logic [255:0] weights;

    // Single-word instance (1 word per layer, base 4)
    logic         req_valid1, req_ready1, mem_rd_en1, data_ready1, err1, busy1;
    logic [3:0]   req_layer1;
    logic [7:0]   mem_addr1;
    logic [31:0]  mem_rdata1;
    logic [31:0]  weights1;

    int checks = 0;
    int errors = 0;
    int rd_count = 0;
    int rd_count1 = 0;

    mlp_weight_server u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_layer(req_layer),
        .req_ready(req_ready), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .weights(weights), .data_ready(data_ready),
        .err(err), .busy(busy)
    );

    mlp_weight_server #(.WORDS_PER_LAYER(1), .BASE_ADDR(4)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid1), .req_layer(req_layer1),
        .req_ready(req_ready1), .mem_rd_en(mem_rd_en1), .mem_addr(mem_addr1),
        .mem_rdata(mem_rdata1), .weights(weights1), .data_ready(data_ready1),
        .err(err1), .busy(busy1)
    );

    function automatic logic [31:0] sram_word(input logic [7:0] a);
        return {8'hC0, a, 8'h5A, ~a};
    endfunction

    function automatic logic [255:0] layer_weights(input int base);
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = sram_word(8'(base + k));
        return r;
    endfunction

    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rdata <= sram_word(mem_addr);
            rd_count  <= rd_count + 1;
        end
        if (mem_rd_en1) begin
            mem_rdata1 <= sram_word(mem_addr1);
            rd_count1  <= rd_count1 + 1;
        end
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        req_valid = 1'b0;  req_layer = '0;
        req_valid1 = 1'b0; req_layer1 = '0;
        tick(2);
        check("rst_req_ready", req_ready, 0);
        check("rst_rd_en", mem_rd_en, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_weights", weights, 0);
        check("rst_data_ready", data_ready, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        rst = 1'b1;
        tick(1);
        check("post_rst_req_ready", req_ready, 1);

        // Miss on layer 2: addresses 16..23 on cycles 1..8, data_ready at cycle 10
        req_valid = 1'b1; req_layer = 4'd2;
        tick(1);
        req_valid = 1'b0;
        check("miss_busy", busy, 1);
        check("miss_req_ready", req_ready, 0);
        check("miss_dr_low", data_ready, 0);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("miss_rd_en_c%0d", k + 1), mem_rd_en, 1);
            check($sformatf("miss_addr_c%0d", k + 1), mem_addr, 16 + k);
            tick(1);
        end
        check("miss_rd_en_c9", mem_rd_en, 0);
        check("miss_dr_c9", data_ready, 0);
        tick(1);
        check("miss_dr_c10", data_ready, 1);
        check("miss_err", err, 0);
        check("miss_busy_done", busy, 0);
        check("miss_req_ready_done", req_ready, 1);
        check("miss_w_lo", weights[31:0], 32'hC010_5AEF);
        check("miss_w_hi", weights[255:224], 32'hC017_5AE8);
        check("miss_w_all", weights, layer_weights(16));
        check("miss_reads", rd_count, 8);

        // Repeat layer 2 straight from DONE: cache hit
        req_valid = 1'b1; req_layer = 4'd2;
        tick(1);
        req_valid = 1'b0;
        check("hit_dr", data_ready, 1);
        check("hit_err", err, 0);
        check("hit_busy", busy, 0);
        check("hit_rd_en", mem_rd_en, 0);
        tick(3);
        check("hit_reads", rd_count, 8);
        check("hit_weights", weights, layer_weights(16));

        // Out-of-range layer 5, then layer 2 hits again
        req_valid = 1'b1; req_layer = 4'd5;
        tick(1);
        req_valid = 1'b0;
        check("oob_err", err, 1);
        check("oob_dr", data_ready, 1);
        check("oob_rd_en", mem_rd_en, 0);
        check("oob_weights", weights, layer_weights(16));
        tick(2);
        check("oob_reads", rd_count, 8);
        req_valid = 1'b1; req_layer = 4'd2;
        tick(1);
        req_valid = 1'b0;
        check("rehit_err", err, 0);
        check("rehit_dr", data_ready, 1);
        tick(2);
        check("rehit_reads", rd_count, 8);

        // Layer 0 fetch with a layer-3 request raised at cycle 4 and held
        req_valid = 1'b1; req_layer = 4'd0;
        tick(1);
        req_valid = 1'b0;
        check("l0_dr_low", data_ready, 0);
        check("l0_addr_c1", mem_addr, 0);
        check("l0_rd_en_c1", mem_rd_en, 1);
        tick(3);
        req_valid = 1'b1; req_layer = 4'd3;
        check("l0_req_ready_c4", req_ready, 0);
        tick(1);
        check("l0_addr_c5", mem_addr, 4);
        check("l0_busy_c5", busy, 1);
        tick(4);
        check("l0_dr_c9", data_ready, 0);
        tick(1);
        check("l0_dr_c10", data_ready, 1);
        check("l0_req_ready_c10", req_ready, 1);
        check("l0_w_lo", weights[31:0], 32'hC000_5AFF);
        check("l0_weights", weights, layer_weights(0));
        check("l0_reads", rd_count, 16);
        tick(1);
        req_valid = 1'b0;
        check("l3_addr_c1", mem_addr, 24);
        check("l3_rd_en_c1", mem_rd_en, 1);
        check("l3_dr_low", data_ready, 0);
        check("l3_busy", busy, 1);

        // Asynchronous reset in the middle of the layer-3 fetch
        tick(4);
        #2 rst = 1'b0;
        #1;
        check("arst_rd_en", mem_rd_en, 0);
        check("arst_addr", mem_addr, 0);
        check("arst_weights", weights, 0);
        check("arst_dr", data_ready, 0);
        check("arst_err", err, 0);
        check("arst_busy", busy, 0);
        check("arst_req_ready", req_ready, 0);
        tick(1);
        rst = 1'b1;
        tick(1);
        check("arst_rel_req_ready", req_ready, 1);
        req_valid = 1'b1; req_layer = 4'd2;
        tick(1);
        req_valid = 1'b0;
        check("refetch_rd_en", mem_rd_en, 1);
        check("refetch_addr", mem_addr, 16);
        check("refetch_dr_low", data_ready, 0);
        tick(9);
        check("refetch_dr_c10", data_ready, 1);
        check("refetch_weights", weights, layer_weights(16));

        // Reset while DONE must also drop the cached layer
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        tick(1);
        req_valid = 1'b1; req_layer = 4'd2;
        tick(1);
        req_valid = 1'b0;
        check("cache_clr_rd_en", mem_rd_en, 1);
        check("cache_clr_dr_low", data_ready, 0);
        tick(10);

        // One word per layer at base 4: layer 3 reads address 7 once
        req_valid1 = 1'b1; req_layer1 = 4'd3;
        tick(1);
        req_valid1 = 1'b0;
        check("w1_rd_en_c1", mem_rd_en1, 1);
        check("w1_addr_c1", mem_addr1, 7);
        tick(1);
        check("w1_rd_en_c2", mem_rd_en1, 0);
        check("w1_dr_c2", data_ready1, 0);
        tick(1);
        check("w1_dr_c3", data_ready1, 1);
        check("w1_err", err1, 0);
        check("w1_weights", weights1, 32'hC007_5AF8);
        check("w1_reads", rd_count1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
